// File: rtl/sw_pkg.sv
// Shared parameters and helpers for the switch debouncer.
package sw_pkg;

    localparam int NUM_SW_DEFAULT      = 3;
    localparam int DB_CYCLES_DEFAULT   = 1_000_000;
    localparam int DB_CYCLES_SIM       = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Counter width able to hold every value 0..n.
    function automatic int db_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer chain, stability counter and accepted level.
// upd_o flags the edge on which the level register is about to take a new value.
module debounce_bit
    import sw_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o,
    output logic upd_o
);

    localparam int CW = db_cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        upd_o   = 1'b0;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_s;
            cnt_d   = '0;
            upd_o   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioner: per-bit sync + debounce, with a merged change strobe.
// Define SW_DEBOUNCE_EDGE_EN to add per-bit rise/fall pulse outputs.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int NUM_SW      = NUM_SW_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_in,
    output logic [NUM_SW-1:0] sw_out,
    output logic              changed
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic [NUM_SW-1:0] rise,
    output logic [NUM_SW-1:0] fall
`endif
);

    logic [NUM_SW-1:0] upd;
    logic              changed_q, changed_d;

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_i    (sw_in[gi]),
            .level_o (sw_out[gi]),
            .upd_o   (upd[gi])
        );
    end

    // Registered alongside the level flops so the strobe lines up with the new sw_out.
    assign changed_d = |upd;
    assign changed   = changed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [NUM_SW-1:0] rise_q, rise_d;
    logic [NUM_SW-1:0] fall_q, fall_d;

    // An updating bit always flips, so the current level tells the direction.
    assign rise_d = upd & ~sw_out;
    assign fall_d = upd &  sw_out;
    assign rise   = rise_q;
    assign fall   = fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
`endif

endmodule
